mm_result_drain: RTL and testbench
==================================

Name: mm_result_drain

Overview:
- Reader end of the mm result interface: on each rising edge of mm `done`, snapshots all N*N `acc_out`/`exp_out` values in one cycle.
- Streams the snapshot out one PE per beat, row-major, over a valid/ready handshake to the host/writeback path.
- Lets the array start its next tile while the previous results drain.

Parameters:
ACC_WIDTH, 32, accumulator width per PE
EXP_WIDTH, 5, shared-exponent width per PE
N, 2, systolic array dimension; N*N results per tile
IDX_W, $clog2(N*N) (min 1), beat index width (derived, localparam)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
done  in  1  mm completion level; rising edge triggers a capture
acc_in  in  N*N*ACC_WIDTH  flattened acc_out; PE[r][c] at slice (r*N+c)
exp_in  in  N*N*EXP_WIDTH  flattened exp_out, same indexing
out_valid  out  1  beat valid
out_ready  in  1  downstream accept
out_data  out  ACC_WIDTH  accumulator of current PE
out_exp  out  EXP_WIDTH  exponent of current PE
out_row  out  $clog2(N) (min 1)  row of current PE
out_col  out  $clog2(N) (min 1)  column of current PE
out_last  out  1  high on beat index N*N-1
busy  out  1  high from capture until final handshake
overrun  out  1  sticky: a done edge arrived while busy
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=0, done_q=0, overrun=0. Snapshot bank cleared to 0. All outputs 0.
- Edge detect: done_rise = done & ~done_q; done_q registered every cycle. A done held high yields exactly one capture.
- FSM states IDLE, STREAM.
- IDLE:
  - On done_rise at edge t, load all N*N acc/exp into the snapshot bank, set idx=0, go to STREAM.
  - out_valid=1 and busy=1 from cycle t+1. Capture latency is 1 cycle.
- STREAM:
  - out_data/out_exp = bank[idx]; out_row = idx/N; out_col = idx%N; out_last = (idx==N*N-1).
  - Handshake = out_valid & out_ready. On handshake, idx increments. If out_last, go to IDLE and idx=0; out_valid and busy drop the next cycle.
  - With out_ready held high, drains one beat per cycle: N*N cycles total.
  - While out_valid & ~out_ready, all out_* fields are held stable.
- Overrun: done_rise while in STREAM (including the cycle of the final handshake) is ignored: no recapture, bank unchanged. It sets overrun=1.
- overrun clears only on clr_overrun=1 or reset. If set and clear coincide, set wins.
- Back-to-back tiles: done must fall and rise again after return to IDLE. A done_rise in the first IDLE cycle is captured normally.
- Reset mid-stream: immediate return to IDLE, out_valid=0, snapshot discarded, no partial resume.
- No arithmetic; values pass bit-exact. idx compare is against the constant N*N-1.

Decomposition:
- Shared package mm_pkg: EXP_WIDTH, default ACC_WIDTH, FSM state encoding (IDLE=0, STREAM=1), index-width helper function.
- One natural sub-module: mm_snapshot_bank (N*N x (ACC_WIDTH+EXP_WIDTH) parallel-load, indexed-read register file).
- FSM, edge detect and handshake stay in the top.

Test Plan:
1. Ready always high. acc_in = {FFFF9000, FFFFA800, FFFFAC00, FFFFC800} (PE3..PE0), exp_in=15 for all, pulse done.
   -> 4 consecutive beats starting 1 cycle after the edge: C800@(0,0), AC00@(0,1), A800@(1,0), 9000@(1,1), exp=15. out_last only on beat 4. busy low the cycle after.
2. Backpressure: same data, out_ready toggles 1,0,0,1,0,1,1.
   -> Fields stable during ready=0. Exactly 4 handshakes, same order, no beat duplicated or dropped.
3. Snapshot isolation: after capture, change acc_in to 0x12345678 while streaming.
   -> Streamed values remain the captured FFFF.... set.
4. Overrun: second done rise during beat 2.
   -> overrun=1 and sticky, stream unchanged. clr_overrun pulse -> overrun=0.
5. done held high for 20 cycles.
   -> Exactly one 4-beat stream. A later fall then rise yields a second stream.
6. Assert rst=0 mid-beat 3 (async, between edges).
   -> out_valid, busy, overrun, out_data all 0 immediately. After release with no done edge: no beats.

Source files
------------

// File: rtl/mm_result_drain_pkg.sv
// Shared definitions for the mm result drain block.
//   ACC_WIDTH_DEF / EXP_WIDTH_DEF : default per-PE accumulator / exponent widths
//   state_t                       : drain FSM encoding (IDLE=0, STREAM=1)
//   idx_width()                   : index width for n entries, never below 1
package mm_pkg;

  localparam int ACC_WIDTH_DEF = 32;
  localparam int EXP_WIDTH_DEF = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_result_drain_if.sv
// Result stream from the drain to the host/writeback path.
//   valid/ready : handshake, beat transfers when both are high
//   data        : accumulator of the current PE
//   exp_val     : shared exponent of the current PE
//   row/col     : PE coordinates of the current beat
//   last        : final beat of the tile
interface mm_result_drain_if #(
  parameter int ACC_WIDTH = 32,
  parameter int EXP_WIDTH = 5,
  parameter int RC_W      = 1
);
  logic                 valid;
  logic                 ready;
  logic [ACC_WIDTH-1:0] data;
  logic [EXP_WIDTH-1:0] exp_val;
  logic [RC_W-1:0]      row;
  logic [RC_W-1:0]      col;
  logic                 last;

  modport master (output valid, data, exp_val, row, col, last, input ready);
  modport slave  (input valid, data, exp_val, row, col, last, output ready);
endinterface

// File: rtl/mm_result_drain_bank.sv
// Snapshot register file: all N*N acc/exp pairs load in one cycle, one entry
// is read combinationally by index.
//   i_load       : parallel load of the full flattened inputs
//   i_acc/i_exp  : flattened PE values, PE[r][c] at slice r*N+c
//   i_idx        : read index
//   o_acc/o_exp  : entry at i_idx
module mm_snapshot_bank #(
  parameter int ACC_WIDTH = 32,
  parameter int EXP_WIDTH = 5,
  parameter int N         = 2,
  parameter int IDX_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic [N*N*ACC_WIDTH-1:0]   i_acc,
  input  logic [N*N*EXP_WIDTH-1:0]   i_exp,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [ACC_WIDTH-1:0]       o_acc,
  output logic [EXP_WIDTH-1:0]       o_exp
);
  localparam int NN = N * N;

  logic [ACC_WIDTH-1:0] r_acc [NN];
  logic [EXP_WIDTH-1:0] r_exp [NN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NN; i++) begin
        r_acc[i] <= '0;
        r_exp[i] <= '0;
      end
    end else if (i_load) begin
      for (int i = 0; i < NN; i++) begin
        r_acc[i] <= i_acc[i*ACC_WIDTH +: ACC_WIDTH];
        r_exp[i] <= i_exp[i*EXP_WIDTH +: EXP_WIDTH];
      end
    end
  end

  assign o_acc = r_acc[i_idx];
  assign o_exp = r_exp[i_idx];
endmodule

// File: rtl/mm_result_drain.sv
// Reader end of the mm result interface. A rising edge of i_done snapshots
// every PE result; the snapshot is then streamed row-major, one PE per beat,
// so the array can start its next tile while results drain.
//   i_done        : completion level, rising edge captures
//   i_acc/i_exp   : flattened PE results
//   i_clr_overrun : synchronous clear of o_overrun
//   o_busy        : capture until final handshake
//   o_overrun     : sticky, done edge seen while streaming
//   o_res         : result stream (master side)
//
// state  | meaning
// IDLE   | no snapshot pending, waiting for a done edge
// STREAM | presenting bank[idx], advancing on handshake
module mm_result_drain
  import mm_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int N         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_done,
  input  logic [N*N*ACC_WIDTH-1:0] i_acc,
  input  logic [N*N*EXP_WIDTH-1:0] i_exp,
  input  logic                     i_clr_overrun,
  output logic                     o_busy,
  output logic                     o_overrun,
  mm_result_drain_if.master        o_res
);
  localparam int NN    = N * N;
  localparam int IDX_W = idx_width(NN);
  localparam int RC_W  = idx_width(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  state_t             r_state, w_state_nx;
  logic [IDX_W-1:0]   r_idx, w_idx_nx;
  logic               r_done_q;
  logic               r_overrun;
  logic               w_load;
  logic               w_done_rise;
  logic               w_busy;
  logic               w_last;
  logic               w_hs;
  logic [31:0]        w_idx32;
  logic [ACC_WIDTH-1:0] w_acc;
  logic [EXP_WIDTH-1:0] w_exp;

  assign w_done_rise = i_done & ~r_done_q;
  assign w_busy      = (r_state == ST_STREAM);
  assign w_last      = (r_idx == LAST_IDX);
  assign w_hs        = w_busy & o_res.ready;
  assign w_idx32     = 32'(r_idx);

  mm_snapshot_bank #(
    .ACC_WIDTH (ACC_WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .N         (N),
    .IDX_W     (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_acc  (i_acc),
    .i_exp  (i_exp),
    .i_idx  (r_idx),
    .o_acc  (w_acc),
    .o_exp  (w_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_done_q  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_done_q <= i_done;
      // A new edge while streaming is dropped; flag it, set beats clear.
      if (w_busy && w_done_rise)
        r_overrun <= 1'b1;
      else if (i_clr_overrun)
        r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_done_rise) begin
          w_load     = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_idx + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // Fields are forced to zero outside STREAM so an idle stream shows nothing stale.
  assign o_res.valid   = w_busy;
  assign o_res.data    = w_busy ? w_acc : '0;
  assign o_res.exp_val = w_busy ? w_exp : '0;
  assign o_res.row     = w_busy ? RC_W'(w_idx32 / 32'(N)) : '0;
  assign o_res.col     = w_busy ? RC_W'(w_idx32 % 32'(N)) : '0;
  assign o_res.last    = w_busy & w_last;
  assign o_busy        = w_busy;
  assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_mm_result_drain.sv
module tb_mm_result_drain;
  localparam int N  = 2;
  localparam int NN = N * N;
  localparam int AW = 32;
  localparam int EW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            done = 1'b0;
  logic            clr = 1'b0;
  logic [NN*AW-1:0] acc_in = '0;
  logic [NN*EW-1:0] exp_in = '0;
  logic            busy;
  logic            overrun;

  mm_result_drain_if #(.ACC_WIDTH(AW), .EXP_WIDTH(EW), .RC_W(1)) res ();

  mm_result_drain #(.ACC_WIDTH(AW), .EXP_WIDTH(EW), .N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_done        (done),
    .i_acc         (acc_in),
    .i_exp         (exp_in),
    .i_clr_overrun (clr),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_res         (res.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  int ready_mode = 0;
  int pk = 0;
  int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a captured tile becomes NN beats in row-major order.
  task automatic push_tile(input logic [NN*AW-1:0] a, input logic [NN*EW-1:0] e);
    for (int i = 0; i < NN; i++) begin
      logic [AW-1:0] av;
      logic [EW-1:0] ev;
      av = a[i*AW +: AW];
      ev = e[i*EW +: EW];
      exp_q.push_back({av, ev, 1'(i / N), 1'(i % N), (i == NN - 1) ? 1'b1 : 1'b0});
    end
  endtask

  initial begin
    res.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: res.ready = 1'b1;
        1: res.ready = ($urandom_range(0, 3) != 0);
        default: begin
          res.ready = pat[pk % 7][0];
          pk++;
        end
      endcase
    end
  end

  // Monitor: pops an expected beat on every handshake, checks hold under stall.
  logic        prev_stall = 1'b0;
  logic [39:0] held = '0;
  logic [39:0] cur;
  logic [39:0] b;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {res.data, res.exp_val, res.row, res.col, res.last};
      if (prev_stall) chk("hold_stable", 64'(cur), 64'(held));
      if (res.valid && res.ready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("beat", 64'(cur), 64'(b));
        end
      end
      prev_stall = res.valid && !res.ready;
      held = cur;
    end
  end

  // Called from IDLE: raises done for one cycle and checks capture latency.
  task automatic start_tile(input logic [NN*AW-1:0] a, input logic [NN*EW-1:0] e);
    @(posedge clk);
    #1;
    done = 1'b1;
    acc_in = a;
    exp_in = e;
    push_tile(a, e);
    @(negedge clk);
    chk("idle_before_capture", 64'(res.valid), 64'd0);
    @(posedge clk);
    #1;
    done = 1'b0;
    @(negedge clk);
    chk("capture_latency_valid", 64'(res.valid), 64'd1);
    chk("capture_latency_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    chk({name, "_busy_low"}, 64'(busy), 64'd0);
    chk({name, "_valid_low"}, 64'(res.valid), 64'd0);
  endtask

  logic [NN*AW-1:0] base_acc;
  logic [NN*EW-1:0] base_exp;

  initial begin
    base_acc = {32'hFFFF9000, 32'hFFFFA800, 32'hFFFFAC00, 32'hFFFFC800};
    base_exp = {5'd15, 5'd15, 5'd15, 5'd15};

    #3;
    chk("reset_valid", 64'(res.valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    chk("reset_data", 64'(res.data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_beat", 64'(res.valid), 64'd0);

    // 1: ready always high, exactly four back-to-back beats
    ready_mode = 0;
    start_tile(base_acc, base_exp);
    repeat (3) @(negedge clk);
    chk("t1_last_beat_valid", 64'(res.valid), 64'd1);
    chk("t1_last_beat_flag", 64'(res.last), 64'd1);
    wait_drain("t1");

    // 2: patterned backpressure
    ready_mode = 2;
    pk = 0;
    start_tile(base_acc, base_exp);
    wait_drain("t2");

    // 3: inputs change while streaming, snapshot must hold
    ready_mode = 1;
    start_tile(base_acc, base_exp);
    acc_in = {NN{32'h12345678}};
    exp_in = {NN{5'd3}};
    wait_drain("t3");

    // 4: overrun, including a coincident clear where set must win
    ready_mode = 0;
    start_tile(base_acc, base_exp);
    chk("t4_overrun_clear", 64'(overrun), 64'd0);
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    @(negedge clk);
    chk("t4_overrun_set", 64'(overrun), 64'd1);
    @(posedge clk); #1 begin done = 1'b1; clr = 1'b1; end
    @(posedge clk); #1 begin done = 1'b0; clr = 1'b0; end
    @(negedge clk);
    chk("t4_set_wins", 64'(overrun), 64'd1);
    wait_drain("t4");
    chk("t4_sticky", 64'(overrun), 64'd1);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("t4_cleared", 64'(overrun), 64'd0);

    // 5: done held high gives one stream; fall then rise gives another
    @(posedge clk); #1;
    done = 1'b1;
    acc_in = base_acc;
    exp_in = base_exp;
    push_tile(base_acc, base_exp);
    repeat (20) @(posedge clk);
    #1 done = 1'b0;
    wait_drain("t5a");
    chk("t5_no_overrun", 64'(overrun), 64'd0);
    start_tile({32'h1, 32'h2, 32'h3, 32'h4}, {5'd1, 5'd2, 5'd3, 5'd4});
    wait_drain("t5b");

    // randomized tiles with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 12; t++) begin
      logic [NN*AW-1:0] ra;
      logic [NN*EW-1:0] re;
      for (int i = 0; i < NN; i++) begin
        ra[i*AW +: AW] = $urandom;
        re[i*EW +: EW] = EW'($urandom_range(0, 31));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      start_tile(ra, re);
      wait_drain("rnd");
    end

    // 6: asynchronous reset in the middle of beat 3
    ready_mode = 0;
    start_tile(base_acc, base_exp);
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(res.valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_overrun", 64'(overrun), 64'd0);
    chk("t6_data", 64'(res.data), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_resume", 64'(res.valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
